// File: rtl/tx_pulse_shaper_if.sv
// Symbol-in / sample-out bus of the transmit pulse shaper.
interface tx_pulse_shaper_if #(
    parameter int WIDTH = 18
);
    logic                    sam_clk_en;
    logic                    sym_clk_en;
    logic                    sym_valid;
    logic [1:0]              sym_in;
    logic signed [WIDTH-1:0] y;

    modport master (output sam_clk_en, sym_clk_en, sym_valid, sym_in, input y);
    modport slave  (input sam_clk_en, sym_clk_en, sym_valid, sym_in, output y);
endinterface

// File: rtl/tx_pulse_shaper.sv
// Polyphase interpolate-by-UPS 4-ASK pulse shaper. The dot product of the
// symbol delay line with one coefficient phase is built up over four sys_clk
// steps after every sample strobe and loaded, saturated, on the next strobe.
module tx_pulse_shaper #(
    parameter int WIDTH  = 18,
    parameter int LENGTH = 101,
    parameter int UPS    = 4
) (
    input  logic             sys_clk,
    input  logic             reset,
    tx_pulse_shaper_if.slave bus
);
    localparam int unsigned UPS_U    = UPS;
    localparam int unsigned LENGTH_U = LENGTH;
    localparam int unsigned HALF     = (LENGTH_U - 1) / 2;
    localparam int unsigned NSYM     = (LENGTH_U + UPS_U - 1) / UPS_U;
    localparam int unsigned NSTEP    = 4;
    localparam int unsigned CHUNK    = (NSYM + NSTEP - 1) / NSTEP;
    localparam int unsigned PW       = (UPS > 1) ? $clog2(UPS) : 1;
    localparam int unsigned LW       = $clog2(3 * NSYM);
    localparam int unsigned COEF_W   = 18;
    localparam int unsigned ACC_W    = 24;
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);

    logic [3*NSYM-1:0]       line_q, line_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [2:0]              step_q, step_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic signed [ACC_W-1:0] chunk_c;
    logic signed [ACC_W-1:0] sum_c;
    int unsigned             tap_k;

    // Lower half of the symmetric prototype; taps past the end read as zero.
    function automatic logic signed [COEF_W-1:0] coef(input int unsigned n);
        int unsigned m;
        if (n > LENGTH_U - 1) return '0;
        m = (n <= HALF) ? n : LENGTH_U - 1 - n;
        case (m)
            0:  return  18'sd73;    1:  return -18'sd7;     2:  return -18'sd89;
            3:  return -18'sd99;    4:  return -18'sd22;    5:  return  18'sd95;
            6:  return  18'sd178;   7:  return  18'sd170;   8:  return  18'sd52;
            9:  return -18'sd118;   10: return -18'sd232;   11: return -18'sd205;
            12: return -18'sd41;    13: return  18'sd168;   14: return  18'sd300;
            15: return  18'sd246;   16: return  18'sd21;    17: return -18'sd235;
            18: return -18'sd385;   19: return -18'sd290;   20: return  18'sd14;
            21: return  18'sd326;   22: return  18'sd497;   23: return  18'sd340;
            24: return -18'sd71;    25: return -18'sd459;   26: return -18'sd657;
            27: return -18'sd403;   28: return  18'sd168;   29: return  18'sd671;
            30: return  18'sd904;   31: return  18'sd490;   32: return -18'sd345;
            33: return -18'sd1048;  34: return -18'sd1339;  35: return -18'sd627;
            36: return  18'sd718;   37: return  18'sd1882;  38: return  18'sd2318;
            39: return  18'sd898;   40: return -18'sd1815;  41: return -18'sd4570;
            42: return -18'sd5600;  43: return -18'sd3020;  44: return  18'sd2150;
            45: return  18'sd7800;  46: return  18'sd9500;  47: return  18'sd17000;
            48: return  18'sd23440; 49: return  18'sd34770; 50: return  18'sd39137;
            default: return '0;
        endcase
    endfunction

    // Level times coefficient using shift-add for |level| = 3 and negation for sign.
    function automatic logic signed [ACC_W-1:0] tap_prod(input logic signed [2:0] lvl,
                                                        input logic signed [COEF_W-1:0] h);
        logic signed [ACC_W-1:0] h1;
        logic signed [ACC_W-1:0] mag;
        h1 = ACC_W'(h);
        case (lvl)
            3'sd1, -3'sd1: mag = h1;
            3'sd3, -3'sd3: mag = h1 + (h1 <<< 1);
            default:       mag = '0;
        endcase
        return lvl[2] ? -mag : mag;
    endfunction

    function automatic logic signed [2:0] map_level(input logic [1:0] s);
        case (s)
            2'b00:   return -3'sd3;
            2'b01:   return -3'sd1;
            2'b10:   return  3'sd1;
            default: return  3'sd3;
        endcase
    endfunction

    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > Y_MAX) return WIDTH'(Y_MAX);
        if (v < Y_MIN) return WIDTH'(Y_MIN);
        return WIDTH'(v);
    endfunction

    // Partial sum of the CHUNK symbol taps owned by the current step.
    always_comb begin
        chunk_c = '0;
        tap_k   = '0;
        for (int j = 0; j < int'(CHUNK); j++) begin
            tap_k = CHUNK * 32'(step_q) + 32'(j);
            if ((step_q < 3'(NSTEP)) && (tap_k < NSYM)) begin
                chunk_c = chunk_c + tap_prod(line_q[LW'(3 * tap_k) +: 3],
                                             coef(UPS_U * tap_k + 32'(phase_q)));
            end
        end
    end

    // Strobe handling: load y, restart accumulation, shift line and step phase.
    always_comb begin
        sum_c   = acc_q + chunk_c;
        line_d  = line_q;
        phase_d = phase_q;
        step_d  = step_q;
        acc_d   = sum_c;
        y_d     = y_q;
        if (bus.sam_clk_en) begin
            y_d    = saturate(sum_c);
            acc_d  = '0;
            step_d = '0;
            if (bus.sym_clk_en) begin
                phase_d = '0;
                line_d  = {line_q[3*NSYM-4:0],
                           bus.sym_valid ? map_level(bus.sym_in) : 3'sd0};
            end else begin
                phase_d = (phase_q == PW'(UPS - 1)) ? '0 : phase_q + PW'(1);
            end
        end else if (step_q < 3'(NSTEP)) begin
            step_d = step_q + 3'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            line_q  <= '0;
            phase_q <= '0;
            step_q  <= '0;
            acc_q   <= '0;
            y_q     <= '0;
        end else begin
            line_q  <= line_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    assign bus.y = y_q;
endmodule

// File: tb/tb_tx_pulse_shaper.sv
// Bench for tx_pulse_shaper: a direct dot-product model over the full
// 101-tap prototype, checked on every strobe and every idle cycle.
module tb_tx_pulse_shaper;
    localparam int WIDTH  = 18;
    localparam int LENGTH = 101;
    localparam int UPS    = 4;
    localparam int NSYM   = (LENGTH + UPS - 1) / UPS;
    localparam int IMP_N  = 108;
    localparam int Y_MAX  = 131071;
    localparam int Y_MIN  = -131072;

    logic sys_clk = 1'b0;
    logic reset;

    tx_pulse_shaper_if #(.WIDTH(WIDTH)) bus ();

    tx_pulse_shaper #(.WIDTH(WIDTH), .LENGTH(LENGTH), .UPS(UPS)) dut (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int h_half[51] = '{73, -7, -89, -99, -22, 95, 178, 170, 52, -118, -232, -205, -41,
                       168, 300, 246, 21, -235, -385, -290, 14, 326, 497, 340, -71, -459,
                       -657, -403, 168, 671, 904, 490, -345, -1048, -1339, -627, 718, 1882,
                       2318, 898, -1815, -4570, -5600, -3020, 2150, 7800, 9500, 17000,
                       23440, 34770, 39137};
    int h_full[LENGTH];
    int lv[NSYM];
    int ph;
    int exp_y;
    int vectors     = 0;
    int miscompares = 0;
    int resp[IMP_N];
    int resp11[IMP_N];
    int sample_idx  = 0;

    function automatic int level_of(input logic [1:0] s);
        return 2 * int'(s) - 3;
    endfunction

    function automatic int model_raw();
        int acc = 0;
        for (int k = 0; k < NSYM; k++) begin
            if (UPS * k + ph < LENGTH) acc += h_full[UPS * k + ph] * lv[k];
        end
        return acc;
    endfunction

    function automatic int clamp(input int v);
        if (v > Y_MAX) return Y_MAX;
        if (v < Y_MIN) return Y_MIN;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NSYM; k++) lv[k] = 0;
        ph    = 0;
        exp_y = 0;
    endtask

    task automatic model_strobe(input bit sym, input bit valid, input logic [1:0] s);
        exp_y = clamp(model_raw());
        if (sym) begin
            for (int k = NSYM - 1; k > 0; k--) lv[k] = lv[k - 1];
            lv[0] = valid ? level_of(s) : 0;
            ph    = 0;
        end else begin
            ph = (ph + 1) % UPS;
        end
    endtask

    // One sample period: strobe, check y, then gap-1 idle cycles checking hold.
    task automatic do_sample(input bit sym, input bit valid, input logic [1:0] s,
                             input int gap, input bit stray, input string tag,
                             output int obs);
        logic signed [WIDTH-1:0] e;
        @(negedge sys_clk);
        bus.sam_clk_en = 1'b1;
        bus.sym_clk_en = sym;
        bus.sym_valid  = valid;
        bus.sym_in     = s;
        @(posedge sys_clk);
        #1;
        model_strobe(sym, valid, s);
        e   = WIDTH'(exp_y);
        obs = int'(bus.y);
        vectors++;
        if (bus.y !== e) begin
            miscompares++;
            $display("FAIL %s sample %0d: y=%0d expected %0d", tag, sample_idx, bus.y, exp_y);
        end
        sample_idx++;
        for (int i = 1; i < gap; i++) begin
            @(negedge sys_clk);
            vectors++;
            if (bus.y !== e) begin
                miscompares++;
                $display("FAIL %s hold cycle %0d after sample %0d: y=%0d expected %0d",
                         tag, i, sample_idx - 1, bus.y, exp_y);
            end
            bus.sam_clk_en = 1'b0;
            bus.sym_clk_en = stray && (i == 1);
            bus.sym_valid  = 1'($urandom);
            bus.sym_in     = 2'($urandom);
        end
    endtask

    task automatic apply_reset(input string tag);
        @(negedge sys_clk);
        reset          = 1'b1;
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        @(posedge sys_clk);
        #1;
        model_reset();
        vectors++;
        if (bus.y !== '0) begin
            miscompares++;
            $display("FAIL %s reset: y=%0d expected 0", tag, bus.y);
        end
        @(negedge sys_clk);
        reset = 1'b0;
    endtask

    task automatic rand_traffic(input int n, input string tag);
        int  cnt = 0;
        int  obs;
        bit  sym;
        for (int i = 0; i < n; i++) begin
            sym = (cnt == UPS - 1) || ($urandom_range(0, 29) == 0);
            cnt = sym ? 0 : cnt + 1;
            do_sample(sym, $urandom_range(0, 4) != 0, 2'($urandom),
                      $urandom_range(4, 6), $urandom_range(0, 7) == 0, tag, obs);
        end
    endtask

    task automatic test_reset();
        int obs;
        reset          = 1'b1;
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        bus.sym_valid  = 1'b0;
        bus.sym_in     = 2'b00;
        repeat (3) @(negedge sys_clk);
        // strobes with a full-scale symbol on the reset edge must be ignored
        bus.sam_clk_en = 1'b1;
        bus.sym_clk_en = 1'b1;
        bus.sym_valid  = 1'b1;
        bus.sym_in     = 2'b11;
        @(posedge sys_clk);
        #1;
        model_reset();
        vectors++;
        if (bus.y !== '0) begin
            miscompares++;
            $display("FAIL reset_priority: y=%0d expected 0", bus.y);
        end
        @(negedge sys_clk);
        reset          = 1'b0;
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        for (int i = 0; i < 12; i++) do_sample(i % UPS == 0, 1'b0, 2'b11, 4, 1'b0, "post_reset", obs);
    endtask

    task automatic test_impulse(input logic [1:0] s);
        int obs;
        apply_reset("impulse");
        for (int i = 0; i < 8; i++) do_sample(i % UPS == 0, 1'b0, 2'b00, 4, 1'b0, "impulse", obs);
        do_sample(1'b1, 1'b1, s, 4, 1'b0, "impulse", obs);
        for (int j = 0; j < IMP_N; j++) begin
            do_sample((j + 1) % UPS == 0, 1'b0, 2'($urandom), 4, 1'b0, "impulse", obs);
            resp[j] = obs;
        end
    endtask

    task automatic test_impulse_pos();
        int head[5] = '{219, -21, -267, -297, -66};
        test_impulse(2'b11);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (resp[i] !== head[i]) begin
                miscompares++;
                $display("FAIL impulse11 offset %0d: y=%0d expected %0d", i, resp[i], head[i]);
            end
        end
        vectors++;
        if (resp[50] !== 117411) begin
            miscompares++;
            $display("FAIL impulse11 offset 50: y=%0d expected 117411", resp[50]);
        end
        for (int j = 101; j < IMP_N; j++) begin
            vectors++;
            if (resp[j] !== 0) begin
                miscompares++;
                $display("FAIL impulse11 tail offset %0d: y=%0d expected 0", j, resp[j]);
            end
        end
        resp11 = resp;
    endtask

    task automatic test_impulse_neg();
        int head[4] = '{-73, 7, 89, 99};
        test_impulse(2'b01);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (resp[i] !== head[i]) begin
                miscompares++;
                $display("FAIL impulse01 offset %0d: y=%0d expected %0d", i, resp[i], head[i]);
            end
        end
        test_impulse(2'b00);
        for (int j = 0; j < IMP_N; j++) begin
            vectors++;
            if (resp[j] !== -resp11[j]) begin
                miscompares++;
                $display("FAIL impulse00 offset %0d: y=%0d expected %0d", j, resp[j], -resp11[j]);
            end
        end
    endtask

    // Levels of +/-3 matching the signs of the phase-2 taps drive y to the rail.
    task automatic test_saturation(input bit flip);
        int obs;
        int n;
        int want;
        bit neg;
        apply_reset("saturation");
        for (int k = NSYM - 1; k >= 0; k--) begin
            n   = UPS * k + 2;
            neg = (n < LENGTH) && (h_full[n] < 0);
            do_sample(1'b1, 1'b1, (neg ^ flip) ? 2'b00 : 2'b11, 4, 1'b0, "saturation", obs);
        end
        for (int i = 0; i < 3; i++) do_sample(1'b0, 1'b0, 2'b00, 4, 1'b0, "saturation", obs);
        want = flip ? Y_MIN : Y_MAX;
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL saturation phase2 flip=%0d: y=%0d expected %0d", flip, obs, want);
        end
    endtask

    task automatic test_strobe_rules();
        int obs;
        apply_reset("strobe_rules");
        for (int i = 0; i < 40; i++)
            do_sample(i % UPS == 0, 1'b1, 2'($urandom), 4, 1'b1, "strobe_rules", obs);
    endtask

    task automatic test_random();
        apply_reset("random");
        rand_traffic(400, "random");
    endtask

    task automatic test_reset_mid();
        rand_traffic(50, "pre_reset");
        apply_reset("mid_stream");
        rand_traffic(110, "post_mid_reset");
    endtask

    initial begin
        for (int n = 0; n < LENGTH; n++) h_full[n] = h_half[(n <= 50) ? n : LENGTH - 1 - n];
        model_reset();
        test_reset();
        test_impulse_pos();
        test_impulse_neg();
        test_saturation(1'b0);
        test_saturation(1'b1);
        test_strobe_rules();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
